// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_slave_pkg;

  // Protocol phase of the target.
  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWdata,
    StWack,
    StRdata,
    StRack
  } state_e;

  // SDA level during the acknowledge bit.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_slave_sync.sv
// Synchronises SCL/SDA into the system clock domain and flags SCL edges and
// START/STOP conditions. All flags come from the synchronised/delayed pair, so
// every detection lands two cycles after the pad change.
module i2c_slave_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_s_o
);

  logic scl_s1_q, scl_s2_q, scl_d_q;
  logic sda_s1_q, sda_s2_q, sda_d_q;

  // Two-flop synchroniser plus one delay stage per line; idle bus level is 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_d_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_d_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl_i;
      scl_s2_q <= scl_s1_q;
      scl_d_q  <= scl_s2_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
      sda_d_q  <= sda_s2_q;
    end
  end

  // SDA changes are only conditions when SCL is stable high across the sample.
  always_comb begin
    scl_rise_o  = scl_s2_q & ~scl_d_q;
    scl_fall_o  = ~scl_s2_q & scl_d_q;
    start_det_o = scl_s2_q & scl_d_q & sda_d_q & ~sda_s2_q;
    stop_det_o  = scl_s2_q & scl_d_q & ~sda_d_q & sda_s2_q;
    sda_s_o     = sda_s2_q;
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with a small byte-addressed register file. The first byte of a
// write sets the pointer, later bytes are stored at the pointer, and reads
// stream out from the pointer; the pointer auto-increments and wraps.
module i2c_slave_regfile
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h10,
  parameter int unsigned MEM_AW     = 3
) (
  input  logic              wb_clk_i,
  input  logic              arst_i,
  input  logic              scl_pad_i,
  input  logic              sda_pad_i,
  output logic              sda_pad_o,
  output logic              sda_padoen_o,
  output logic              busy_o,
  output logic              wr_stb_o,
  output logic [MEM_AW-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o
);

  localparam int unsigned Depth = 1 << MEM_AW;

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_slave_sync u_sync (
    .clk_i       (wb_clk_i),
    .rst_ni      (arst_i),
    .scl_i       (scl_pad_i),
    .sda_i       (sda_pad_i),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det),
    .sda_s_o     (sda_s)
  );

  state_e            state_q;
  logic [3:0]        bitcnt_q;
  logic [7:0]        shreg_q;
  logic              rw_q;
  logic              first_q;
  logic              rack_q;
  logic [MEM_AW-1:0] ptr_q;
  logic              padoen_q;
  logic              busy_q;
  logic              wr_stb_q;
  logic [MEM_AW-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [7:0]        mem_q [Depth];

  // Protocol FSM, register file and all registered outputs.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q   <= StIdle;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      rw_q      <= 1'b0;
      first_q   <= 1'b0;
      rack_q    <= NACK;
      ptr_q     <= '0;
      padoen_q  <= 1'b1;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_stb_q <= 1'b0;
      // Bus conditions override whatever bit-level event shares the cycle.
      if (start_det) begin
        state_q  <= StAddr;
        bitcnt_q <= '0;
        padoen_q <= 1'b1;
        busy_q   <= 1'b1;
      end else if (stop_det) begin
        state_q  <= StIdle;
        padoen_q <= 1'b1;
        busy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            padoen_q <= 1'b1;
          end
          StAddr: begin
            if (scl_rise && bitcnt_q != 4'd8) begin
              shreg_q  <= {shreg_q[6:0], sda_s};
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (scl_fall && bitcnt_q == 4'd8) begin
              if (shreg_q[7:1] == SLAVE_ADDR) begin
                padoen_q <= ACK;
                rw_q     <= shreg_q[0];
                state_q  <= StAddrAck;
              end else begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end
            end
          end
          StAddrAck: begin
            if (scl_fall) begin
              if (!rw_q) begin
                padoen_q <= 1'b1;
                first_q  <= 1'b1;
                bitcnt_q <= '0;
                state_q  <= StWdata;
              end else begin
                shreg_q  <= mem_q[ptr_q];
                padoen_q <= mem_q[ptr_q][7];
                bitcnt_q <= 4'd1;
                state_q  <= StRdata;
              end
            end
          end
          StWdata: begin
            if (scl_rise && bitcnt_q != 4'd8) begin
              shreg_q  <= {shreg_q[6:0], sda_s};
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (scl_fall && bitcnt_q == 4'd8) begin
              padoen_q <= ACK;
              if (first_q) begin
                ptr_q <= shreg_q[MEM_AW-1:0];
              end else begin
                mem_q[ptr_q] <= shreg_q;
                wr_stb_q     <= 1'b1;
                wr_addr_q    <= ptr_q;
                wr_data_q    <= shreg_q;
                ptr_q        <= ptr_q + MEM_AW'(1);
              end
              state_q <= StWack;
            end
          end
          StWack: begin
            if (scl_fall) begin
              padoen_q <= 1'b1;
              first_q  <= 1'b0;
              bitcnt_q <= '0;
              state_q  <= StWdata;
            end
          end
          StRdata: begin
            // bitcnt_q counts bits already put on the line.
            if (scl_fall) begin
              if (bitcnt_q == 4'd8) begin
                padoen_q <= 1'b1;
                ptr_q    <= ptr_q + MEM_AW'(1);
                state_q  <= StRack;
              end else begin
                padoen_q <= shreg_q[6];
                shreg_q  <= {shreg_q[6:0], 1'b0};
                bitcnt_q <= bitcnt_q + 4'd1;
              end
            end
          end
          StRack: begin
            if (scl_rise) begin
              rack_q <= sda_s;
            end else if (scl_fall) begin
              if (rack_q == ACK) begin
                shreg_q  <= mem_q[ptr_q];
                padoen_q <= mem_q[ptr_q][7];
                bitcnt_q <= 4'd1;
                state_q  <= StRdata;
              end else begin
                padoen_q <= 1'b1;
                busy_q   <= 1'b0;
                state_q  <= StIdle;
              end
            end
          end
          default: begin
            state_q  <= StIdle;
            padoen_q <= 1'b1;
          end
        endcase
      end
    end
  end

  // Open-drain: the pad value is fixed low, only the enable moves.
  always_comb begin
    sda_pad_o    = 1'b0;
    sda_padoen_o = padoen_q;
    busy_o       = busy_q;
    wr_stb_o     = wr_stb_q;
    wr_addr_o    = wr_addr_q;
    wr_data_o    = wr_data_q;
  end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- Synthesizable I2C target (slave) that answers the Wishbone I2C master in the verification environment.
- Oversamples SCL/SDA on the system clock and decodes START/STOP and address/data bytes.
- Holds a small byte-addressed register file, written and read through an auto-incrementing pointer.
- Sits on the pad side of the master and closes the open-drain bus loop, so the bench can run self-checking transfers.

Parameters:
- SLAVE_ADDR, 7'h10, 7-bit I2C address this target ACKs.
- MEM_AW, 3, register-file address width; depth = 2**MEM_AW bytes.

Ports:
- wb_clk_i  in  1  system clock; all logic is on the rising edge.
- arst_i  in  1  asynchronous reset, active-low.
- scl_pad_i  in  1  SCL line level (wired-AND of the bus).
- sda_pad_i  in  1  SDA line level.
- sda_pad_o  out  1  SDA output value; constant 1'b0.
- sda_padoen_o  out  1  SDA output enable, active-low: 0 pulls SDA low.
- busy_o  out  1  high from a detected START until STOP or NACK-idle.
- wr_stb_o  out  1  one-cycle pulse when a data byte is committed to memory.
- wr_addr_o  out  MEM_AW  memory address of the committed byte.
- wr_data_o  out  8  committed byte.

Behaviour:
- Reset (arst_i=0):
  - Asynchronous. Outputs: sda_padoen_o=1, busy_o=0, wr_stb_o=0, wr_addr_o=0, wr_data_o=0.
  - state=IDLE, ptr=0, memory cleared to 8'h00, synchronisers preset to 1.
  - Reset mid-transfer releases SDA immediately.
- Input conditioning:
  - Two-flop synchroniser plus one delay flop per line.
  - scl_rise/scl_fall are derived from the delayed pair.
  - Every response lags the pad edge by 3 wb_clk_i cycles. The master's SCL low phase must exceed 4 cycles.
- START: SDA falls while SCL is high. Legal in any state, including a repeated START.
  - Actions: go to ADDR, clear bit counter, release SDA, busy_o=1.
- STOP: SDA rises while SCL is high, any state.
  - Actions: go to IDLE, release SDA, busy_o=0.
- Bit sampling and driving:
  - SDA is sampled on scl_rise, MSB first.
  - SDA is driven only after scl_fall.
- State machine:
  - IDLE: waits for START.
  - ADDR: shifts 8 bits. On the 8th scl_fall:
    - addr[7:1]==SLAVE_ADDR: drive ACK (padoen=0), latch rw=bit0, go to ADDR_ACK.
    - Otherwise: stay released, go to IDLE (wait for next START).
  - ADDR_ACK: on scl_fall, release SDA.
    - rw=0: go to WDATA with first_byte=1.
    - rw=1: load mem[ptr] into the shifter, drive its MSB, go to RDATA.
  - WDATA: shifts 8 bits. On the 8th scl_fall, drive ACK, then:
    - first_byte=1: ptr <= byte[MEM_AW-1:0].
    - first_byte=0: mem[ptr] <= byte, pulse wr_stb_o with wr_addr_o=ptr and wr_data_o=byte, then ptr++.
    - Go to WACK.
  - WACK: on scl_fall, release SDA, clear first_byte, go to WDATA.
  - RDATA: on each scl_fall, drive the next bit (padoen = bit value; a 1 releases the line). After the 8th bit's scl_fall, release SDA, ptr++, go to RACK.
  - RACK: sample master ACK on scl_rise.
    - SDA=0: on scl_fall, load mem[ptr], drive MSB, go to RDATA.
    - SDA=1 (NACK): go to IDLE, SDA stays released until START/STOP.
- Pointer: wraps modulo 2**MEM_AW, no error. It persists across transactions until reset.
- Simultaneous events: a START/STOP detected in the same cycle as scl_fall takes priority.
- wr_stb_o is never asserted during read states.

Decomposition:
- Package i2c_slave_pkg:
  - state enum (IDLE, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK).
  - constants ACK=1'b0, NACK=1'b1.
- Sub-module i2c_slave_sync: two-flop synchroniser plus edge/START/STOP detector, one instance covering both lines. Outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

Test Plan:
- Write:
  - Stimulus: master writes 0x20 (addr 0x10, W), 0x02, 0xA5, then STOP.
  - Required: slave ACKs all 3 bytes; one wr_stb_o with wr_addr_o=2, wr_data_o=8'hA5; busy_o drops after STOP.
- Read:
  - Stimulus: after the write above, write 0x20, 0x02, repeated START, 0x21, read 2 bytes (ACK then NACK), STOP.
  - Required: master RXR reads 0xA5 then 0x00; SDA released after the NACK.
- Address mismatch:
  - Stimulus: master sends 0x22 (addr 0x11).
  - Required: sda_padoen_o stays 1 throughout; master sees RxACK=1; no wr_stb_o.
- Pointer wrap:
  - Stimulus: write ptr 0x07, data 0x11, 0x22.
  - Required: wr_stb_o at addr 7 (0x11) then addr 0 (0x22); a later read from ptr 7 returns 0x11, 0x22.
- Reset mid-read:
  - Stimulus: drop arst_i while the slave drives a 0 bit.
  - Required: sda_padoen_o=1 in the same cycle; busy_o=0; next transfer starts cleanly with memory reading 0x00.
